// File: rtl/complete_arb_pkg.sv
// Shared types and helpers for the FU-to-ROB completion arbiter.
// Optional perf counters are enabled with COMPLETE_ARBITER_PERF_EN (see complete_arbiter).
package complete_arb_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PREG_W_DEF = 6;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [PREG_W_DEF-1:0] preg;
        logic [DATA_W_DEF-1:0] data;
    } cmp_result_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin picker: first two set requesters scanning from rr_ptr.
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               grant0_vld,
    output logic [PTR_W-1:0]   grant0_idx,
    output logic               grant1_vld,
    output logic [PTR_W-1:0]   grant1_idx,
    output logic [PTR_W-1:0]   next_ptr
);

    // Rotating scan; the first hit fills slot 0, the second fills slot 1.
    always_comb begin
        int             sum_v;
        int             nxt_v;
        logic [PTR_W-1:0] idx_s;
        logic [PTR_W-1:0] last_s;
        logic           take0_s;
        logic           take1_s;
        sum_v      = 0;
        nxt_v      = 0;
        idx_s      = {PTR_W{1'b0}};
        last_s     = {PTR_W{1'b0}};
        take0_s    = 1'b0;
        take1_s    = 1'b0;
        grant0_vld = 1'b0;
        grant0_idx = {PTR_W{1'b0}};
        grant1_vld = 1'b0;
        grant1_idx = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v      = int'(rr_ptr) + k;
            sum_v      = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
            idx_s      = PTR_W'(sum_v);
            take0_s    = req[idx_s] & ~grant0_vld;
            take1_s    = req[idx_s] & grant0_vld & ~grant1_vld;
            grant0_idx = take0_s ? idx_s : grant0_idx;
            grant1_idx = take1_s ? idx_s : grant1_idx;
            grant0_vld = grant0_vld | take0_s;
            grant1_vld = grant1_vld | take1_s;
        end
        last_s   = grant1_vld ? grant1_idx : grant0_idx;
        nxt_v    = int'(last_s) + 1;
        nxt_v    = (nxt_v >= NUM_REQ) ? 0 : nxt_v;
        next_ptr = grant0_vld ? PTR_W'(nxt_v) : rr_ptr;
    end

endmodule

// File: rtl/complete_arbiter.sv
// Collects FU writeback results into per-FU holds and completes up to two per cycle to the ROB.
// Define COMPLETE_ARBITER_PERF_EN to add grant/stall performance counters.
module complete_arbiter
    import complete_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PC_W    = PC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PREG_W  = PREG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    fu_valid,
    output logic [NUM_REQ-1:0]    fu_ready,
    input  logic [NUM_REQ*PC_W-1:0]   fu_pc,
    input  logic [NUM_REQ*PREG_W-1:0] fu_preg,
    input  logic [NUM_REQ*DATA_W-1:0] fu_data,
    output logic [1:0]            cmp_valid,
    output logic [2*PC_W-1:0]     cmp_pc,
    output logic [2*PREG_W-1:0]   cmp_preg,
    output logic [2*DATA_W-1:0]   cmp_data,
    input  logic                  rob_ready
`ifdef COMPLETE_ARBITER_PERF_EN
    ,
    output logic [31:0]           perf_grant_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             hold_valid_r;
    logic [NUM_REQ-1:0][PC_W-1:0]   hold_pc_r;
    logic [NUM_REQ-1:0][PREG_W-1:0] hold_preg_r;
    logic [NUM_REQ-1:0][DATA_W-1:0] hold_data_r;

    logic [1:0]                     cmp_valid_r;
    logic [1:0][PC_W-1:0]           cmp_pc_r;
    logic [1:0][PREG_W-1:0]         cmp_preg_r;
    logic [1:0][DATA_W-1:0]         cmp_data_r;
    logic [PTR_W-1:0]               rr_ptr_r;

    logic                           adv_s;
    logic [NUM_REQ-1:0]             cap_s;
    logic [NUM_REQ-1:0]             clr_s;
    logic                           g0_vld_s;
    logic                           g1_vld_s;
    logic [PTR_W-1:0]               g0_idx_s;
    logic [PTR_W-1:0]               g1_idx_s;
    logic [PTR_W-1:0]               next_ptr_s;

    // Capture only into free holds and grant only from full ones, so the two never touch one entry.
    assign adv_s    = ~(|cmp_valid_r) | rob_ready;
    assign cap_s    = fu_valid & ~hold_valid_r;
    assign fu_ready = ~hold_valid_r;

    assign cmp_valid = cmp_valid_r;
    assign cmp_pc    = cmp_pc_r;
    assign cmp_preg  = cmp_preg_r;
    assign cmp_data  = cmp_data_r;

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req        (hold_valid_r),
        .rr_ptr     (rr_ptr_r),
        .grant0_vld (g0_vld_s),
        .grant0_idx (g0_idx_s),
        .grant1_vld (g1_vld_s),
        .grant1_idx (g1_idx_s),
        .next_ptr   (next_ptr_s)
    );

    // Mask of holds released by this cycle's grant.
    always_comb begin
        clr_s           = {NUM_REQ{1'b0}};
        clr_s[g0_idx_s] = clr_s[g0_idx_s] | (adv_s & g0_vld_s);
        clr_s[g1_idx_s] = clr_s[g1_idx_s] | (adv_s & g1_vld_s);
    end

    // Per-FU holding registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_valid_r <= {NUM_REQ{1'b0}};
            hold_pc_r    <= '{default: {PC_W{1'b0}}};
            hold_preg_r  <= '{default: {PREG_W{1'b0}}};
            hold_data_r  <= '{default: {DATA_W{1'b0}}};
        end else begin
            hold_valid_r <= (hold_valid_r & ~clr_s) | cap_s;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap_s[i]) begin
                    hold_pc_r[i]   <= fu_pc[i*PC_W +: PC_W];
                    hold_preg_r[i] <= fu_preg[i*PREG_W +: PREG_W];
                    hold_data_r[i] <= fu_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output stage and round-robin pointer; everything freezes while the ROB stalls a full stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmp_valid_r <= 2'b00;
            cmp_pc_r    <= '{default: {PC_W{1'b0}}};
            cmp_preg_r  <= '{default: {PREG_W{1'b0}}};
            cmp_data_r  <= '{default: {DATA_W{1'b0}}};
            rr_ptr_r    <= {PTR_W{1'b0}};
        end else if (adv_s) begin
            cmp_valid_r <= {g1_vld_s, g0_vld_s};
            rr_ptr_r    <= next_ptr_s;
            if (g0_vld_s) begin
                cmp_pc_r[0]   <= hold_pc_r[g0_idx_s];
                cmp_preg_r[0] <= hold_preg_r[g0_idx_s];
                cmp_data_r[0] <= hold_data_r[g0_idx_s];
            end
            if (g1_vld_s) begin
                cmp_pc_r[1]   <= hold_pc_r[g1_idx_s];
                cmp_preg_r[1] <= hold_preg_r[g1_idx_s];
                cmp_data_r[1] <= hold_data_r[g1_idx_s];
            end
        end
    end

`ifdef COMPLETE_ARBITER_PERF_EN
    logic [31:0] perf_grant_cnt_r;
    logic [31:0] perf_stall_cnt_r;

    assign perf_grant_cnt = perf_grant_cnt_r;
    assign perf_stall_cnt = perf_stall_cnt_r;

    // Free-running wrap-around counters of granted results and stalled edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_grant_cnt_r <= 32'd0;
            perf_stall_cnt_r <= 32'd0;
        end else begin
            if (adv_s) begin
                perf_grant_cnt_r <= perf_grant_cnt_r + {30'd0, popcount2({g1_vld_s, g0_vld_s})};
            end
            if ((|cmp_valid_r) && !rob_ready) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: directed vectors push expected completions, a monitor pops them.
module tb_complete_arbiter;
    import complete_arb_pkg::*;

    typedef struct packed {
        logic        slot;
        cmp_result_t res;
    } exp_t;

    logic              clk;
    logic              rstn;
    logic [3:0]        fu_valid;
    logic [3:0]        fu_ready;
    logic [3:0][31:0]  fu_pc_a;
    logic [3:0][5:0]   fu_preg_a;
    logic [3:0][31:0]  fu_data_a;
    logic [1:0]        cmp_valid;
    logic [1:0][31:0]  cmp_pc_a;
    logic [1:0][5:0]   cmp_preg_a;
    logic [1:0][31:0]  cmp_data_a;
    logic              rob_ready;
`ifdef COMPLETE_ARBITER_PERF_EN
    logic [31:0]       perf_grant_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic fair_mode;
    int   fair_f0 = 0;
    int   fair_f3 = 0;

    complete_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_pc     (fu_pc_a),
        .fu_preg   (fu_preg_a),
        .fu_data   (fu_data_a),
        .cmp_valid (cmp_valid),
        .cmp_pc    (cmp_pc_a),
        .cmp_preg  (cmp_preg_a),
        .cmp_data  (cmp_data_a),
        .rob_ready (rob_ready)
`ifdef COMPLETE_ARBITER_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] pg(input logic [31:0] pc);
        return pc[7:2] ^ 6'h2A;
    endfunction

    function automatic logic [31:0] dt(input logic [31:0] pc);
        return {16'hD0D0, pc[15:0]};
    endfunction

    task automatic load(input int i, input logic [31:0] pc);
        fu_pc_a[i]   = pc;
        fu_preg_a[i] = pg(pc);
        fu_data_a[i] = dt(pc);
    endtask

    task automatic push(input logic slot, input logic [31:0] pc);
        exp_t e;
        e.slot     = slot;
        e.res.pc   = pc;
        e.res.preg = pg(pc);
        e.res.data = dt(pc);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (sb_q.size() == 0 && cmp_valid == 2'b00 && fu_ready == 4'hF) done = 1'b1;
            else tick();
        end
        chk(nm, {63'd0, done}, 64'd1);
    endtask

    task automatic do_reset();
        fu_valid  = 4'h0;
        rob_ready = 1'b0;
        rstn      = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Monitor: every slot the ROB takes is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && rob_ready && cmp_valid != 2'b00) begin
            chk("slot_order", {62'd0, cmp_valid == 2'b10}, 64'd0);
            for (int s = 0; s < 2; s++) begin
                if (cmp_valid[s]) begin
                    if (fair_mode) begin
                        chk("fair_pc", {32'd0, cmp_pc_a[s]}, (s == 0) ? 64'h3C0 : 64'h300);
                        if (cmp_pc_a[s] == 32'h300) fair_f0++;
                        if (cmp_pc_a[s] == 32'h3C0) fair_f3++;
                    end else if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra: got pc %h in slot %0d, expected nothing", cmp_pc_a[s], s);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sb_slot", s, {63'd0, e.slot});
                        chk("sb_pc",   {32'd0, cmp_pc_a[s]},   {32'd0, e.res.pc});
                        chk("sb_preg", {58'd0, cmp_preg_a[s]}, {58'd0, e.res.preg});
                        chk("sb_data", {32'd0, cmp_data_a[s]}, {32'd0, e.res.data});
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; fu_valid = 4'h0; rob_ready = 1'b0; fair_mode = 1'b0;
        fu_pc_a = '0; fu_preg_a = '0; fu_data_a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cv",    {62'd0, cmp_valid}, 64'd0);
        chk("reset_ready", {60'd0, fu_ready},  64'hF);
        rstn = 1'b1;
        tick();

        // Single result from FU2, two-edge latency
        rob_ready = 1'b1;
        fu_pc_a[2] = 32'h40; fu_preg_a[2] = 6'd5; fu_data_a[2] = 32'hDEAD;
        begin
            exp_t e;
            e.slot = 1'b0; e.res.pc = 32'h40; e.res.preg = 6'd5; e.res.data = 32'hDEAD;
            sb_q.push_back(e);
        end
        fu_valid = 4'b0100;
        tick();
        fu_valid = 4'h0;
        chk("single_ready_busy", {60'd0, fu_ready}, 64'hB);
        chk("single_cv_wait",    {62'd0, cmp_valid}, 64'd0);
        tick();
        chk("single_cv",         {62'd0, cmp_valid}, 64'd1);
        chk("single_ready_free", {60'd0, fu_ready}, 64'hF);
        tick();
        chk("single_empty", {62'd0, cmp_valid}, 64'd0);

        // Fill everything with the ROB stalled, then reset mid-traffic
        rob_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(i, 32'h200 + 32'(i * 4));
        fu_valid = 4'hF;
        repeat (3) tick();
        chk("full_ready", {60'd0, fu_ready}, 64'h0);
        chk("full_cv",    {62'd0, cmp_valid}, 64'd3);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_cv",    {62'd0, cmp_valid}, 64'd0);
        chk("midrst_ready", {60'd0, fu_ready}, 64'hF);
        chk("midrst_pc",    cmp_pc_a, 64'd0);
        fu_valid = 4'h0;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // All four at once from rr_ptr=0: {0,1} then {2,3}
        rob_ready = 1'b1;
        for (int i = 0; i < 4; i++) load(i, 32'h100 + 32'(i * 4));
        push(1'b0, 32'h100); push(1'b1, 32'h104); push(1'b0, 32'h108); push(1'b1, 32'h10C);
        fu_valid = 4'hF;
        tick();
        fu_valid = 4'h0;
        tick();
        chk("all4_cv_a", {62'd0, cmp_valid}, 64'd3);
        tick();
        chk("all4_cv_b", {62'd0, cmp_valid}, 64'd3);
        drain("all4_drain");

        // Pointer is back at 0: FU1 precedes FU3
        load(1, 32'h180); load(3, 32'h18C);
        push(1'b0, 32'h180); push(1'b1, 32'h18C);
        fu_valid = 4'b1010;
        tick();
        fu_valid = 4'h0;
        drain("ptr_drain");

        // Single FU0 grant leaves rr_ptr=1
        load(0, 32'h1C0);
        push(1'b0, 32'h1C0);
        fu_valid = 4'b0001;
        tick();
        fu_valid = 4'h0;
        drain("ptr1_drain");

        // Fairness: FU0 and FU3 continuously valid from rr_ptr=1
        fair_mode = 1'b1;
        load(0, 32'h300); load(3, 32'h3C0);
        fu_valid = 4'b1001;
        repeat (100) tick();
        fu_valid = 4'h0;
        drain("fair_drain");
        fair_mode = 1'b0;
        chk("fair_diff", {63'd0, ((fair_f0 > fair_f3) ? (fair_f0 - fair_f3) : (fair_f3 - fair_f0)) <= 1}, 64'd1);
        chk("fair_min",  {63'd0, fair_f0 >= 40}, 64'd1);

        // Backpressure: 8 results, outputs frozen while the ROB stalls
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 32'h500 + 32'(i * 4));
        fu_valid = 4'hF;
        tick();
        for (int i = 0; i < 4; i++) load(i, 32'h600 + 32'(i * 4));
        push(1'b0, 32'h500); push(1'b1, 32'h504); push(1'b0, 32'h508); push(1'b1, 32'h50C);
        push(1'b0, 32'h600); push(1'b1, 32'h604); push(1'b0, 32'h608); push(1'b1, 32'h60C);
        tick();
        tick();
        fu_valid = 4'b1100;
        for (int c = 0; c < 5; c++) begin
            chk("bp_cv",    {62'd0, cmp_valid}, 64'd3);
            chk("bp_pc",    cmp_pc_a, {32'h504, 32'h500});
            chk("bp_ready", {60'd0, fu_ready}, 64'h0);
            tick();
        end
        rob_ready = 1'b1;
        tick();
        tick();
        fu_valid = 4'h0;
        drain("bp_drain");

        // Counter scenario: 6 grants, 3 stall edges
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 32'h700 + 32'(i * 4));
        push(1'b0, 32'h700); push(1'b1, 32'h704); push(1'b0, 32'h708); push(1'b1, 32'h70C);
        push(1'b0, 32'h780); push(1'b1, 32'h784);
        fu_valid = 4'hF;
        tick();
        load(0, 32'h780); load(1, 32'h784);
        fu_valid = 4'b0011;
        tick();
        tick();
        fu_valid = 4'h0;
        tick();
        tick();
        rob_ready = 1'b1;
        drain("perf_drain");
`ifdef COMPLETE_ARBITER_PERF_EN
        chk("perf_grant", {32'd0, perf_grant_cnt}, 64'd6);
        chk("perf_stall", {32'd0, perf_stall_cnt}, 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Sits between the four functional-unit writeback ports and the reorder buffer's completion inputs.
- Each FU result is captured in a one-entry holding register per requester.
- Up to 2 results per cycle are granted round-robin into a registered 2-slot output stage.
- The output stage drives the ROB complete-PC and data ports under a valid/ready handshake, so FUs stall instead of dropping results when the ROB cannot absorb them.

Parameters:
- NUM_REQ, 4, number of FU requesters (2..8).
- PC_W, 32, instruction PC width.
- DATA_W, 32, result data width.
- PREG_W, 6, physical destination register width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: asynchronous, active-low.
- fu_valid  in  NUM_REQ  per-FU result valid.
- fu_ready  out  NUM_REQ  per-FU holding register free.
- fu_pc  in  NUM_REQ*PC_W  per-FU result PC, requester i at bits [i*PC_W +: PC_W].
- fu_preg  in  NUM_REQ*PREG_W  per-FU physical destination.
- fu_data  in  NUM_REQ*DATA_W  per-FU result data.
- cmp_valid  out  2  output slot valid; slot 0 always filled before slot 1.
- cmp_pc  out  2*PC_W  completing PC per slot.
- cmp_preg  out  2*PREG_W  completing physical register per slot.
- cmp_data  out  2*DATA_W  completing data per slot.
- rob_ready  in  1  ROB accepts both slots this cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - all hold_valid = 0; cmp_valid = 0; cmp_pc, cmp_preg, cmp_data = 0; rr_ptr = 0.
  - In-flight results are discarded.
- fu_ready[i] = ~hold_valid[i]. It is purely registered state, with no combinational path from rob_ready or grant.
- Capture: on a clk edge with fu_valid[i] & fu_ready[i], hold[i] loads {pc, preg, data} and hold_valid[i] is set.
  - fu_valid while fu_ready is low is ignored. The FU must hold its result.
- Output advance condition: adv = ~|cmp_valid | rob_ready.
- Grant, when adv = 1:
  - Scan hold_valid starting at rr_ptr, modulo NUM_REQ.
  - The first set requester goes to slot 0 and the second to slot 1.
  - Granted hold_valid bits are cleared at the edge. cmp_valid takes the grant mask; 00 is loaded if nothing is pending.
- Grant, when adv = 0: output stage, hold registers and rr_ptr are all unchanged.
- rr_ptr update: becomes (last granted index + 1) mod NUM_REQ. It is unchanged if no grant occurred.
- A hold cleared by a grant at edge E reports fu_ready=1 after E. A new capture can happen at E+1 at the earliest, so capture and grant never collide on the same register.
- Latency:
  - FU handshake at edge E0 -> eligible for grant at E1 -> cmp_valid visible after E1.
  - Minimum 2 edges from FU accept to ROB presentation.
  - Sustained throughput is 2 results per cycle.
- Output stability: while cmp_valid != 0 and rob_ready = 0, all cmp_* outputs hold their values.
- Full condition: all holds valid and output stalled -> fu_ready all 0. No loss and no overwrite.
- Empty condition: cmp_valid = 00. Data fields keep their last value and are don't-care.
- Ordering: no PC ordering is guaranteed across FUs. The ROB matches by PC. Within one FU, results are in capture order.

Optional Feature:
- Macro: COMPLETE_ARBITER_PERF_EN.
- Enabled: adds output ports perf_grant_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_grant_cnt increments by the popcount of granted slots each advancing edge.
  - perf_stall_cnt increments each edge where cmp_valid != 0 and rob_ready = 0.
  - Both wrap at 2^32.
- Disabled: these ports and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package complete_arb_pkg holds:
  - PC_W, DATA_W and PREG_W defaults.
  - typedef cmp_result_t {pc, preg, data}.
  - Function popcount2.
- One sub-module: rr_pick2, purely combinational. Inputs: req vector and rr_ptr. Outputs: grant0/grant1 indices with valids and next_ptr.
- Hold registers, output stage and counters stay in complete_arbiter.

Test Plan:
- Reset mid-traffic: assert rstn=0 with hold_valid=1111 and cmp_valid=11 -> immediately cmp_valid=00, fu_ready=1111; after release, rr_ptr=0.
- Single result: FU2 pc=0x40, preg=5, data=0xDEAD, rob_ready=1 -> 2 edges later slot0={0x40,5,0xDEAD}, cmp_valid=01; fu_ready[2] returns 1 one edge after capture+grant.
- All four FUs valid at once with rob_ready=1 -> grants {0,1} then {2,3} on consecutive edges; rr_ptr goes 0 -> 2 -> 0.
- Fairness: FU0 and FU3 continuously valid, rr_ptr=1 -> slot0=FU3, slot1=FU0. Neither starves over 100 cycles; grant counts differ by at most 1.
- Backpressure: rob_ready=0 for 5 cycles with cmp_valid=11 -> outputs stable; new FU results fill holds and then fu_ready goes 0. On rob_ready=1, no result is lost; check all PCs are delivered exactly once.
- PERF_EN build: 6 grants and 3 stall edges -> perf_grant_cnt=6, perf_stall_cnt=3.
